// File: rtl/pll_config_apb.sv
// rtl/pll_config_apb.sv - APB register block that applies PLL divider settings through a bypass/lock sequence
module pll_config_apb #(
   parameter int XLEN = 64
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic            PSEL,
   input  logic            PENABLE,
   input  logic            PWRITE,
   input  logic [7:0]      PADDR,
   input  logic [XLEN-1:0] PWDATA,
   output logic [XLEN-1:0] PRDATA,
   output logic            PREADY,
   input  logic            PLLlock,
   output logic [5:0]      PLLclkr,
   output logic [12:0]     PLLclkf,
   output logic [3:0]      PLLclkod,
   output logic [11:0]     PLLbwadj,
   output logic            PLLbypass,
   output logic            PLLtest
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BYPASS   = 2'd1,
      LOAD     = 2'd2,
      WAITLOCK = 2'd3
   } state_t;

   localparam logic [5:0] A_CLKR   = 6'd0;
   localparam logic [5:0] A_CLKF   = 6'd1;
   localparam logic [5:0] A_CLKOD  = 6'd2;
   localparam logic [5:0] A_BWADJ  = 6'd3;
   localparam logic [5:0] A_CTRL   = 6'd4;
   localparam logic [5:0] A_STATUS = 6'd5;

   state_t      state, state_next;
   logic [4:0]  settle_cnt, settle_next;
   logic [11:0] timeout_cnt, timeout_next;
   logic        bypass_next;
   logic        set_timeout, set_lostlock;
   logic        timeout_flag, lostlock_flag;
   logic        lock_meta, lock_sync, lock_prev;
   logic [5:0]  sh_clkr;
   logic [12:0] sh_clkf;
   logic [3:0]  sh_clkod;
   logic [11:0] sh_bwadj;
   logic        wr_en, go;
   logic [5:0]  reg_addr;
   logic [31:0] wdata, rdata;
   logic        unused_bits;

   assign wr_en       = PSEL & PENABLE & PWRITE;
   assign reg_addr    = PADDR[7:2];
   assign wdata       = PWDATA[31:0];
   assign go          = wr_en && (reg_addr == A_CTRL) && wdata[0];
   assign PREADY      = 1'b1;
   assign unused_bits = ^{PWDATA, PADDR[1:0]};

   // PLLlock is asynchronous; lock_prev delays the synchronized value for fall detection
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
         lock_prev <= 1'b0;
      end else begin
         lock_meta <= PLLlock;
         lock_sync <= lock_meta;
         lock_prev <= lock_sync;
      end
   end

   always_comb begin
      state_next   = state;
      settle_next  = settle_cnt;
      timeout_next = timeout_cnt;
      bypass_next  = PLLbypass;
      set_timeout  = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               state_next  = BYPASS;
               bypass_next = 1'b1;
               settle_next = 5'd0;
            end
         end
         BYPASS: begin
            if (settle_cnt == 5'd15) state_next = LOAD;
            else                     settle_next = settle_cnt + 5'd1;
         end
         LOAD: begin
            timeout_next = 12'd0;
            state_next   = WAITLOCK;
         end
         WAITLOCK: begin
            if (lock_sync) begin
               bypass_next = 1'b0;
               state_next  = IDLE;
            end else if (timeout_cnt == 12'hFFF) begin
               set_timeout = 1'b1;
               state_next  = IDLE;
            end else begin
               timeout_next = timeout_cnt + 12'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign set_lostlock = (state == IDLE) && !PLLbypass && lock_prev && !lock_sync;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state         <= IDLE;
         settle_cnt    <= 5'd0;
         timeout_cnt   <= 12'd0;
         PLLbypass     <= 1'b1;
         timeout_flag  <= 1'b0;
         lostlock_flag <= 1'b0;
      end else begin
         state       <= state_next;
         settle_cnt  <= settle_next;
         timeout_cnt <= timeout_next;
         PLLbypass   <= bypass_next;
         // A same-cycle set beats the write-1-to-clear
         if (set_timeout)
            timeout_flag <= 1'b1;
         else if (wr_en && (reg_addr == A_STATUS) && wdata[2])
            timeout_flag <= 1'b0;
         if (set_lostlock)
            lostlock_flag <= 1'b1;
         else if (wr_en && (reg_addr == A_STATUS) && wdata[3])
            lostlock_flag <= 1'b0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sh_clkr  <= 6'd0;
         sh_clkf  <= 13'd15;
         sh_clkod <= 4'd1;
         sh_bwadj <= 12'd7;
         PLLclkr  <= 6'd0;
         PLLclkf  <= 13'd15;
         PLLclkod <= 4'd1;
         PLLbwadj <= 12'd7;
         PLLtest  <= 1'b0;
      end else begin
         if (wr_en) begin
            case (reg_addr)
               A_CLKR:  sh_clkr  <= wdata[5:0];
               A_CLKF:  sh_clkf  <= wdata[12:0];
               A_CLKOD: sh_clkod <= wdata[3:0];
               A_BWADJ: sh_bwadj <= wdata[11:0];
               A_CTRL:  PLLtest  <= wdata[1];
               default: ;
            endcase
         end
         if (state == LOAD) begin
            PLLclkr  <= sh_clkr;
            PLLclkf  <= sh_clkf;
            PLLclkod <= sh_clkod;
            PLLbwadj <= sh_bwadj;
         end
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (reg_addr)
         A_CLKR:   rdata[5:0]  = sh_clkr;
         A_CLKF:   rdata[12:0] = sh_clkf;
         A_CLKOD:  rdata[3:0]  = sh_clkod;
         A_BWADJ:  rdata[11:0] = sh_bwadj;
         A_CTRL:   rdata[1]    = PLLtest;
         A_STATUS: rdata[6:0]  = {1'b0, state, lostlock_flag, timeout_flag,
                                  (state != IDLE), lock_sync};
         default:  ;
      endcase
      PRDATA       = '0;
      PRDATA[31:0] = rdata;
   end
endmodule

// File: tb/tb_pll_config_apb.sv
// tb/tb_pll_config_apb.sv - self-checking bench for pll_config_apb against a cycle-level apply model
module tb_pll_config_apb;
   localparam int XLEN = 64;

   logic            PCLK = 1'b0;
   logic            PRESETn;
   logic            PSEL, PENABLE, PWRITE;
   logic [7:0]      PADDR;
   logic [XLEN-1:0] PWDATA;
   logic [XLEN-1:0] PRDATA;
   logic            PREADY;
   logic            PLLlock;
   logic [5:0]      PLLclkr;
   logic [12:0]     PLLclkf;
   logic [3:0]      PLLclkod;
   logic [11:0]     PLLbwadj;
   logic            PLLbypass, PLLtest;

   int checks = 0;
   int failures = 0;
   logic running = 1'b0;

   always #5 PCLK = ~PCLK;

   pll_config_apb #(.XLEN(XLEN)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PLLlock(PLLlock), .PLLclkr(PLLclkr), .PLLclkf(PLLclkf),
      .PLLclkod(PLLclkod), .PLLbwadj(PLLbwadj), .PLLbypass(PLLbypass), .PLLtest(PLLtest)
   );

   // Model: age counts edges since an accepted GO (-1 when idle)
   logic [31:0] m_sh [0:3];
   logic [31:0] m_act [0:3];
   logic        m_bypass, m_test, m_tmo, m_lost;
   int          age;
   logic [2:0]  lh;
   logic        mw, m_sync_now, m_sync_prev, m_set_t, m_set_l;
   int          ma;
   logic [31:0] md;

   function automatic logic [31:0] reg_mask(input int a);
      case (a)
         0: return 32'h3F;
         1: return 32'h1FFF;
         2: return 32'hF;
         default: return 32'hFFF;
      endcase
   endfunction

   task automatic model_reset();
      m_sh[0] = 32'd0; m_sh[1] = 32'd15; m_sh[2] = 32'd1; m_sh[3] = 32'd7;
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_bypass = 1'b1; m_test = 1'b0; m_tmo = 1'b0; m_lost = 1'b0;
      age = -1; lh = 3'b000;
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] addr);
      int a;
      logic [2:0] sc;
      a = int'(addr[7:2]);
      if (age < 0)        sc = 3'd0;
      else if (age <= 15) sc = 3'd1;
      else if (age == 16) sc = 3'd2;
      else                sc = 3'd3;
      case (a)
         0, 1, 2, 3: return m_sh[a];
         4:          return {30'd0, m_test, 1'b0};
         5:          return {25'd0, sc, m_lost, m_tmo, (age >= 0), lh[1]};
         default:    return 32'd0;
      endcase
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         model_reset();
      end else begin
         mw          = PSEL && PENABLE && PWRITE;
         ma          = int'(PADDR[7:2]);
         md          = PWDATA[31:0];
         m_sync_now  = lh[1];
         m_sync_prev = lh[2];
         m_set_t     = 1'b0;
         m_set_l     = (age < 0) && !m_bypass && m_sync_prev && !m_sync_now;
         if (age < 0) begin
            if (mw && ma == 4 && md[0]) begin
               age = 0;
               m_bypass = 1'b1;
            end
         end else begin
            age++;
            if (age == 17) begin
               for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            end else if (age >= 18) begin
               if (m_sync_now) begin
                  m_bypass = 1'b0;
                  age = -1;
               end else if (age - 18 == 4095) begin
                  m_set_t = 1'b1;
                  age = -1;
               end
            end
         end
         if (mw && ma < 4) m_sh[ma] = md & reg_mask(ma);
         if (mw && ma == 4) m_test = md[1];
         if (m_set_t) m_tmo = 1'b1;
         else if (mw && ma == 5 && md[2]) m_tmo = 1'b0;
         if (m_set_l) m_lost = 1'b1;
         else if (mw && ma == 5 && md[3]) m_lost = 1'b0;
         lh = {lh[1:0], PLLlock};
      end
   end

   always @(posedge PCLK) begin
      #1;
      if (running) begin
         checks++;
         if (PLLclkr !== m_act[0][5:0] || PLLclkf !== m_act[1][12:0] ||
             PLLclkod !== m_act[2][3:0] || PLLbwadj !== m_act[3][11:0] ||
             PLLbypass !== m_bypass || PLLtest !== m_test || PREADY !== 1'b1 ||
             PRDATA !== {32'd0, m_read(PADDR)}) begin
            failures++;
            $display("FAIL cycle_model t=%0t actual clkr=%0d clkf=%0d clkod=%0d bwadj=%0d byp=%0b test=%0b rdy=%0b rd=0x%0h expected clkr=%0d clkf=%0d clkod=%0d bwadj=%0d byp=%0b test=%0b rdy=1 rd=0x%0h",
                     $time, PLLclkr, PLLclkf, PLLclkod, PLLbwadj, PLLbypass, PLLtest, PREADY,
                     PRDATA, m_act[0], m_act[1], m_act[2], m_act[3], m_bypass, m_test,
                     m_read(PADDR));
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic peek(input logic [7:0] addr, output logic [31:0] val);
      PADDR = addr;
      #1;
      val = PRDATA[31:0];
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = {32'd0, data};
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int n;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = '0;
      PLLlock = 1'b0; PRESETn = 1'b0;
      model_reset();
      repeat (3) @(negedge PCLK);
      PRESETn = 1'b1;
      running = 1'b1;
      @(negedge PCLK);

      // reset defaults
      peek(8'h00, v); check("rst_clkr", v, 32'd0);
      peek(8'h04, v); check("rst_clkf", v, 32'd15);
      peek(8'h08, v); check("rst_clkod", v, 32'd1);
      peek(8'h0C, v); check("rst_bwadj", v, 32'd7);
      peek(8'h14, v); check("rst_status", v, 32'd0);
      check("rst_bypass", 32'(PLLbypass), 32'd1);
      check("rst_test", 32'(PLLtest), 32'd0);
      check("rst_clkf_out", 32'(PLLclkf), 32'd15);

      // successful apply
      apb_write(8'h04, 32'd40);
      apb_write(8'h10, 32'd1);
      check("go_bypass", 32'(PLLbypass), 32'd1);
      peek(8'h14, v); check("go_status_bypass", v, 32'h12);
      repeat (16) @(posedge PCLK);
      @(negedge PCLK);
      check("clkf_before_load", 32'(PLLclkf), 32'd15);
      peek(8'h14, v); check("status_load", v, 32'h22);
      @(posedge PCLK);
      @(negedge PCLK);
      check("clkf_at_17", 32'(PLLclkf), 32'd40);
      peek(8'h14, v); check("status_waitlock", v, 32'h32);
      repeat (99) @(posedge PCLK);
      @(negedge PCLK);
      PLLlock = 1'b1;
      n = 0;
      while (PLLbypass && n < 20) begin
         @(posedge PCLK);
         @(negedge PCLK);
         n++;
      end
      check("lock_to_unbypass_cycles", 32'(n), 32'd3);
      peek(8'h14, v); check("status_locked_idle", v, 32'h01);

      // lock loss
      PLLlock = 1'b0;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      peek(8'h14, v); check("lostlock_not_yet", v, 32'h00);
      @(posedge PCLK);
      @(negedge PCLK);
      peek(8'h14, v); check("lostlock_set", v, 32'h08);
      check("lostlock_bypass", 32'(PLLbypass), 32'd0);
      check("lostlock_clkf", 32'(PLLclkf), 32'd40);
      apb_write(8'h14, 32'h8);
      peek(8'h14, v); check("lostlock_cleared", v, 32'h00);

      // lock timeout
      apb_write(8'h00, 32'd9);
      apb_write(8'h10, 32'd1);
      repeat (4112) @(posedge PCLK);
      @(negedge PCLK);
      peek(8'h14, v); check("timeout_last_wait", v, 32'h32);
      check("timeout_clkr_loaded", 32'(PLLclkr), 32'd9);
      @(posedge PCLK);
      @(negedge PCLK);
      peek(8'h14, v); check("timeout_set", v, 32'h04);
      check("timeout_bypass", 32'(PLLbypass), 32'd1);
      apb_write(8'h14, 32'h4);
      peek(8'h14, v); check("timeout_cleared", v, 32'h00);

      // timeout set wins over same-cycle clear
      apb_write(8'h10, 32'd1);
      repeat (4110) @(posedge PCLK);
      @(negedge PCLK);
      apb_write(8'h14, 32'h4);
      peek(8'h14, v); check("timeout_set_priority", v, 32'h04);
      apb_write(8'h14, 32'h4);
      peek(8'h14, v); check("timeout_cleared2", v, 32'h00);

      // GO and shadow write while busy
      apb_write(8'h10, 32'd1);
      repeat (29) @(posedge PCLK);
      @(negedge PCLK);
      apb_write(8'h00, 32'd5);
      apb_write(8'h10, 32'd3);
      peek(8'h00, v); check("busy_shadow_clkr", v, 32'd5);
      check("busy_clkr_out", 32'(PLLclkr), 32'd9);
      check("busy_test", 32'(PLLtest), 32'd1);
      peek(8'h14, v); check("busy_no_restart", v, 32'h32);

      // GO landing on the edge the FSM returns to IDLE is dropped
      PLLlock = 1'b1;
      apb_write(8'h10, 32'd3);
      check("go_at_idle_return_bypass", 32'(PLLbypass), 32'd0);
      peek(8'h14, v); check("go_at_idle_return_status", v, 32'h01);
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      peek(8'h14, v); check("go_at_idle_return_later", v, 32'h01);
      check("clkr_after_apply", 32'(PLLclkr), 32'd9);

      // reset mid-apply
      apb_write(8'h10, 32'd3);
      repeat (5) @(posedge PCLK);
      @(negedge PCLK);
      #2;
      PRESETn = 1'b0;
      #1;
      check("rst_mid_clkr", 32'(PLLclkr), 32'd0);
      check("rst_mid_clkf", 32'(PLLclkf), 32'd15);
      check("rst_mid_clkod", 32'(PLLclkod), 32'd1);
      check("rst_mid_bwadj", 32'(PLLbwadj), 32'd7);
      check("rst_mid_bypass", 32'(PLLbypass), 32'd1);
      check("rst_mid_test", 32'(PLLtest), 32'd0);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (40) @(posedge PCLK);
      @(negedge PCLK);
      check("post_rst_bypass", 32'(PLLbypass), 32'd1);
      check("post_rst_clkf", 32'(PLLclkf), 32'd15);
      peek(8'h14, v); check("post_rst_status", v, 32'h01);
      peek(8'h00, v); check("post_rst_shadow_clkr", v, 32'd0);

      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
